// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//
// Multi-channel, run-time programmable clock divider. Each of NUM_CH
// channels produces a 50% duty divided clock with a half-period of D enabled
// system-clock cycles, plus a one-cycle tick strobe in every cycle where its
// divided clock changes level. Divisors can be reloaded at run time; a new
// value is held in a shadow register and only takes effect at the channel's
// next period boundary, so the divided clock never shows a short glitch.
// A divisor of 0 halts the channel with its divided clock held low.
//
// Optional feature (compile-time macro CLKDIV_PHASE_SYNC_EN):
//   Adds input sync_in. A high sync_in restarts every channel from count 0
//   with its divided clock low, applying any pending divisor on the same
//   edge, so channels with equal divisors become phase-aligned.
//
// Parameters:
//   NUM_CH       number of independent channels (1..16)
//   CNT_W        width of each channel's counter and divisor
//   DEFAULT_DIV  half-period divisor loaded at reset (< 2**CNT_W)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   enable        in   [NUM_CH]        per-channel count enable
//   div_load      in   [NUM_CH]        per-channel one-cycle divisor load request
//   div_value     in   [NUM_CH*CNT_W]  divisors; channel i uses [i*CNT_W +: CNT_W]
//   sync_in       in   phase-realignment strobe (CLKDIV_PHASE_SYNC_EN only)
//   dividedClk    out  [NUM_CH]        divided clock per channel (registered)
//   tick          out  [NUM_CH]        strobe in the cycle dividedClk changes
//   load_pending  out  [NUM_CH]        an accepted divisor is waiting to apply
// ---------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         div_load,
  input  logic [NUM_CH*CNT_W-1:0]   div_value,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                      sync_in,
`endif
  output logic [NUM_CH-1:0]         dividedClk,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         load_pending
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] shadow_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] div_m1;
    logic             halted;
    logic             wrap;

    assign load_val = div_value[i*CNT_W +: CNT_W];

    // div_m1 is only consumed when the divisor is non-zero, so its
    // underflow at div_q == 0 never reaches the wrap decision.
    assign halted = (div_q == '0);
    assign div_m1 = div_q - CNT_W'(1);
    assign wrap   = enable[i] && !halted && (cnt_q == div_m1);

    // Per-channel counter, divided clock, tick and divisor bookkeeping.
    // Priority: reset, then phase sync (if built), then halt, then wrap,
    // then ordinary counting. A load accepted outside a wrap waits in the
    // shadow register; a load arriving on a wrap (or while halted) goes
    // straight into the active divisor.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q    <= '0;
        div_q    <= RESET_DIV;
        shadow_q <= RESET_DIV;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end
`ifdef CLKDIV_PHASE_SYNC_EN
      else if (sync_in) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (pend_q) begin
          div_q <= shadow_q;
        end
        if (div_load[i]) begin
          shadow_q <= load_val;
          pend_q   <= 1'b1;
        end else begin
          pend_q   <= 1'b0;
        end
      end
`endif
      else if (halted) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (div_load[i]) begin
          div_q  <= load_val;
          pend_q <= 1'b0;
        end else if (pend_q) begin
          div_q  <= shadow_q;
          pend_q <= 1'b0;
        end
      end else if (wrap) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        tick_q <= 1'b1;
        if (div_load[i]) begin
          div_q  <= load_val;
          pend_q <= 1'b0;
        end else if (pend_q) begin
          div_q  <= shadow_q;
          pend_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
        if (enable[i]) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (div_load[i]) begin
          shadow_q <= load_val;
          pend_q   <= 1'b1;
        end
      end
    end

    assign dividedClk[i]   = clk_q;
    assign tick[i]         = tick_q;
    assign load_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_multi
//
// Scoreboard bench for clock_divider_multi. The stimulus process drives the
// inputs, advances a behavioural reference model on each rising edge and
// pushes the expected outputs into a queue; an independent monitor pops and
// compares on every falling edge. Directed sequences cover reset, enable
// gating, deferred/wrap-cycle/halting loads and async reset, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_divider_multi;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  typedef struct packed {
    logic [NUM_CH-1:0] div;
    logic [NUM_CH-1:0] tck;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH*CNT_W-1:0] div_value;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic                    sync_in;
`endif
  logic [NUM_CH-1:0]       dividedClk;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       load_pending;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model: elapsed enabled edges in the current half-period,
  // active/shadow divisors, pending flag, output level and tick.
  int m_cnt[NUM_CH];
  int m_d[NUM_CH];
  int m_s[NUM_CH];
  bit m_p[NUM_CH];
  bit m_lvl[NUM_CH];
  bit m_tk[NUM_CH];

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .div_load     (div_load),
    .div_value    (div_value),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_in      (sync_in),
`endif
    .dividedClk   (dividedClk),
    .tick         (tick),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0;
      m_d[c]   = DEFAULT_DIV;
      m_s[c]   = DEFAULT_DIV;
      m_p[c]   = 1'b0;
      m_lvl[c] = 1'b0;
      m_tk[c]  = 1'b0;
    end
  endfunction

  // One rising edge of the behavioural model, straight from the channel rules.
  function automatic void modelStep(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ld,
                                    input logic [NUM_CH*CNT_W-1:0] val, input logic sy);
    for (int c = 0; c < NUM_CH; c++) begin
      int v;
      v = int'(val[c*CNT_W +: CNT_W]);
      if (sy) begin
        m_cnt[c] = 0;
        m_lvl[c] = 1'b0;
        m_tk[c]  = 1'b0;
        if (m_p[c]) m_d[c] = m_s[c];
        m_p[c] = 1'b0;
        if (ld[c]) begin
          m_s[c] = v;
          m_p[c] = 1'b1;
        end
      end else if (m_d[c] == 0) begin
        m_cnt[c] = 0;
        m_lvl[c] = 1'b0;
        m_tk[c]  = 1'b0;
        if (ld[c]) begin
          m_d[c] = v;
          m_p[c] = 1'b0;
        end else if (m_p[c]) begin
          m_d[c] = m_s[c];
          m_p[c] = 1'b0;
        end
      end else if (en[c] && (m_cnt[c] + 1 == m_d[c])) begin
        m_cnt[c] = 0;
        m_lvl[c] = !m_lvl[c];
        m_tk[c]  = 1'b1;
        if (ld[c]) begin
          m_d[c] = v;
          m_p[c] = 1'b0;
        end else if (m_p[c]) begin
          m_d[c] = m_s[c];
          m_p[c] = 1'b0;
        end
      end else begin
        m_tk[c] = 1'b0;
        if (en[c]) m_cnt[c] = m_cnt[c] + 1;
        if (ld[c]) begin
          m_s[c] = v;
          m_p[c] = 1'b1;
        end
      end
    end
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      e.div[c]  = m_lvl[c];
      e.tck[c]  = m_tk[c];
      e.pend[c] = m_p[c];
    end
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, queue the result.
  task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ld,
                               input logic [NUM_CH*CNT_W-1:0] val, input logic sy);
    enable    = en;
    div_load  = ld;
    div_value = val;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync_in   = sy;
`endif
    @(posedge clk);
    modelStep(en, ld, val, sy);
    exp_q.push_back(modelOutputs());
    #1;
  endtask

  task automatic loadOne(input int ch, input int v);
    logic [NUM_CH-1:0]       ld;
    logic [NUM_CH*CNT_W-1:0] val;
    ld  = '0;
    val = '0;
    ld[ch] = 1'b1;
    val[ch*CNT_W +: CNT_W] = CNT_W'(v);
    applyStimulus('1, ld, val, 1'b0);
  endtask

  task automatic runCycles(input int n, input logic [NUM_CH-1:0] en);
    for (int k = 0; k < n; k++) applyStimulus(en, '0, '0, 1'b0);
  endtask

  // Advance with all channels enabled until the model reaches a given state.
  task automatic runUntil(input int ch, input int cnt, input int d, input string tag);
    int guard;
    guard = 0;
    while (!(m_d[ch] == d && m_cnt[ch] == cnt) && guard < 60) begin
      applyStimulus('1, '0, '0, 1'b0);
      guard++;
    end
    if (guard >= 60) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: state cnt=%0d d=%0d not reached, got cnt=%0d d=%0d",
               tag, cnt, d, m_cnt[ch], m_d[ch]);
    end
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("dividedClk", 32'(dividedClk), 32'(e.div));
      checkOutput("tick", 32'(tick), 32'(e.tck));
      checkOutput("load_pending", 32'(load_pending), 32'(e.pend));
    end
  end

  initial begin
    reset     = 1'b0;
    enable    = '0;
    div_load  = '0;
    div_value = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync_in   = 1'b0;
`endif
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_dividedClk", 32'(dividedClk), 32'd0);
    checkOutput("reset_tick", 32'(tick), 32'd0);
    checkOutput("reset_load_pending", 32'(load_pending), 32'd0);
    reset = 1'b1;

    // Default divisor: toggles on enabled edges 3, 6, 9
    for (int k = 1; k <= 9; k++) begin
      applyStimulus('1, '0, '0, 1'b0);
      checkOutput("default_tick", 32'(tick), (k % 3 == 0) ? 32'h3 : 32'h0);
      checkOutput("default_level", 32'(dividedClk), (((k / 3) % 2) == 1) ? 32'h3 : 32'h0);
    end

    // Enable gating on ch0 with D=4
    loadOne(0, 4);
    runUntil(0, 2, 4, "gate_setup");
    runCycles(5, 2'b10);
    runCycles(6, 2'b11);

    // Deferred load on ch1: D=5, then load 2 at cnt=1
    loadOne(1, 5);
    runUntil(1, 1, 5, "defer_setup");
    loadOne(1, 2);
    runCycles(14, 2'b11);

    // Load 7 in the exact wrap cycle, then halt with 0, then restart with 1
    runUntil(0, 3, 4, "wrap_setup");
    loadOne(0, 7);
    runCycles(20, 2'b11);
    loadOne(0, 0);
    runCycles(20, 2'b11);
    loadOne(0, 1);
    runCycles(6, 2'b11);

    // Async reset mid-period with a pending load on ch1
    loadOne(1, 6);
    runUntil(1, 0, 6, "areset_setup1");
    loadOne(1, 2);
    runUntil(1, 3, 6, "areset_setup2");
    @(negedge clk);
    #1;
    div_load = '0;
    reset    = 1'b0;
    #1;
    checkOutput("areset_dividedClk", 32'(dividedClk), 32'd0);
    checkOutput("areset_tick", 32'(tick), 32'd0);
    checkOutput("areset_load_pending", 32'(load_pending), 32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    runCycles(10, 2'b11);

`ifdef CLKDIV_PHASE_SYNC_EN
    // Phase sync: ch1 runs 2 cycles ahead, then both realigned
    runCycles(2, 2'b10);
    runCycles(4, 2'b11);
    applyStimulus('1, '0, '0, 1'b1);
    checkOutput("sync_dividedClk", 32'(dividedClk), 32'd0);
    checkOutput("sync_tick", 32'(tick), 32'd0);
    runCycles(12, 2'b11);
`endif

    // Randomized phase
    for (int k = 0; k < 400; k++) begin
      logic [NUM_CH-1:0]       en;
      logic [NUM_CH-1:0]       ld;
      logic [NUM_CH*CNT_W-1:0] val;
      logic                    sy;
      en  = NUM_CH'($urandom);
      ld  = '0;
      val = '0;
      sy  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ld[c] = ($urandom_range(0, 7) == 0);
        val[c*CNT_W +: CNT_W] = ($urandom_range(0, 15) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 6));
      end
`ifdef CLKDIV_PHASE_SYNC_EN
      sy = ($urandom_range(0, 31) == 0);
`endif
      applyStimulus(en, ld, val, sy);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
